// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: zero-register address,
// byte-enable type and the byte merge used by both storage write and bypass.
package regfile_pkg;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned MAX_DATA_W = 64;

  typedef logic [MAX_DATA_W/8-1:0] regfile_byte_en_t;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_d,
    input logic [MAX_DATA_W-1:0] new_d,
    input regfile_byte_en_t      be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_d;
    for (int b = 0; b < MAX_DATA_W/8; b++)
      if (be[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read bus of the multi-port register file; master drives addresses and data.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  logic [NWR-1:0]          we;
  logic [NWR*ADDR_W-1:0]   waddr;
  logic [NWR*DATA_W-1:0]   wdata;
  logic [NWR*DATA_W/8-1:0] wbe;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic                    wr_coll;
  logic [7:0]              coll_cnt;

  modport master (output we, waddr, wdata, wbe, raddr,
                  input  rdata, wr_coll, coll_cnt);
  modport slave  (input  we, waddr, wdata, wbe, raddr,
                  output rdata, wr_coll, coll_cnt);
endinterface

// File: rtl/regfile_mp_wr_arb.sv
// Per-byte write arbitration: qualifies enables (reset, zero register), lets
// port 1 win overlapping bytes on a shared address and flags collisions.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    blk,
  input  logic [NWR-1:0]          we,
  input  logic [NWR*ADDR_W-1:0]   waddr,
  input  logic [NWR*DATA_W/8-1:0] wbe,
  output logic [NWR*DATA_W/8-1:0] be_win,
  output logic                    coll_hit
);
  localparam int NB = DATA_W/8;

  logic [NWR*NB-1:0] be_req;

  always_comb begin
    be_req = '0;
    for (int k = 0; k < NWR; k++)
      if (we[k] && !blk &&
          !(ZERO_REG != 0 && waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))
        be_req[k*NB +: NB] = wbe[k*NB +: NB];
  end

  if (NWR == 2) begin : g_dual
    logic same_addr;
    assign same_addr = (waddr[0 +: ADDR_W] == waddr[ADDR_W +: ADDR_W]);
    assign be_win    = {be_req[NB +: NB],
                        be_req[0 +: NB] & ~({NB{same_addr}} & be_req[NB +: NB])};
    // qualified enables already exclude reset and the zero register
    assign coll_hit  = same_addr && (|(be_req[0 +: NB] & be_req[NB +: NB]));
  end else begin : g_single
    assign be_win   = be_req;
    assign coll_hit = 1'b0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte enables, optional zero
// register, optional write-to-read bypass and write-collision tracking.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam int NB   = DATA_W/8;

  logic [DATA_W-1:0] mem     [NREG];
  logic [DATA_W-1:0] mem_nxt [NREG];
  logic [DATA_W-1:0] rd_src  [NREG];
  logic [NWR*NB-1:0] be_win;
  logic              coll_hit;
  logic              wr_coll_q;
  logic [7:0]        coll_cnt_q;

  regfile_wr_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWR(NWR), .ZERO_REG(ZERO_REG)
  ) u_arb (
    .blk     (rst),
    .we      (bus.we),
    .waddr   (bus.waddr),
    .wbe     (bus.wbe),
    .be_win  (be_win),
    .coll_hit(coll_hit)
  );

  // next-state image of the array; doubles as the bypass source
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      mem_nxt[r] = mem[r];
      for (int k = 0; k < NWR; k++)
        if (bus.waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))
          mem_nxt[r] = DATA_W'(merge_bytes(MAX_DATA_W'(mem_nxt[r]),
                                           MAX_DATA_W'(bus.wdata[k*DATA_W +: DATA_W]),
                                           regfile_byte_en_t'(be_win[k*NB +: NB])));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) mem[r] <= mem_nxt[r];
    end
  end

  if (BYPASS != 0) begin : g_byp
    assign rd_src = mem_nxt;
  end else begin : g_nobyp
    assign rd_src = mem;
  end

  always_comb begin
    bus.rdata = '0;
    for (int j = 0; j < NRD; j++)
      bus.rdata[j*DATA_W +: DATA_W] = rd_src[bus.raddr[j*ADDR_W +: ADDR_W]];
  end

  // coll_hit is constant 0 for a single write port, so these flops fold away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_coll_q  <= 1'b0;
      coll_cnt_q <= 8'd0;
    end else begin
      wr_coll_q <= coll_hit;
      if (coll_hit && coll_cnt_q != 8'hFF) coll_cnt_q <= coll_cnt_q + 8'd1;
    end
  end

  assign bus.wr_coll  = wr_coll_q;
  assign bus.coll_cnt = coll_cnt_q;

endmodule
